hs_buffered_sender: RTL

//  Transmit end of the valid/ready link: a buffered sender feeding a downstream receiver.

---
 rtl/hs_buffered_sender.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hs_buffered_sender.sv
// rtl/hs_buffered_sender.sv - buffered valid/ready sender: FIFO feeding a held output register
//
// Purpose: the local producer pushes {wr_last, wr_data} into a DEPTH-entry FIFO. The output
// stage pops the FIFO head into a register that drives the link. That register is held stable
// until the receiver accepts it. Total capacity is DEPTH + 1 words.
//
// Ports:
//   clk, rst                 rising-edge clock; asynchronous active-low reset
//   wr_en/wr_data/wr_last    push side from the local producer
//   full                     FIFO holds DEPTH entries, so pushes are refused
//   ovf, ovf_clr             sticky overflow flag and its synchronous clear (set wins)
//   data_out/last_out        link word and end-of-packet flag
//   data_out_valid           link valid (registered, independent of ready)
//   data_out_ready           link ready from the receiver
//   level                    words held = FIFO count + data_out_valid
//   pkt_cnt                  packets completed on the link (wraps)
module hs_buffered_sender #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        wr_last,
  output logic                        full,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        last_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [$clog2(DEPTH+2)-1:0]  level,
  output logic [CNT_W-1:0]            pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 2);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t             state, state_next;
  logic [WIDTH:0]     mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, xfer;

  // count is registered, so full reflects the count before the current edge.
  // A pop in the same cycle therefore does not make room for a push.
  assign full           = (count == CW'(DEPTH));
  assign push           = wr_en && !full;
  assign data_out_valid = (state == S_HOLD);
  assign xfer           = data_out_valid && data_out_ready;
  assign level          = LW'(count) + LW'(data_out_valid);

  // Output stage: EMPTY loads whenever the FIFO has data; HOLD reloads or empties on a transfer.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_EMPTY: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (data_out_ready) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_next = S_EMPTY;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Storage array carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      last_out <= 1'b0;
      ovf      <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        {last_out, data_out}   <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (xfer && last_out) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end

endmodule
